// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR unit: CSR addresses, op encodings,
// system funct12 values, FSM states and register bit positions.
package csr_pkg;

    localparam logic [31:0] MTVEC_VAL = 32'h0001_0000;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [2:0] OP_SYS = 3'b000;
    localparam logic [2:0] OP_RW  = 3'b001;
    localparam logic [2:0] OP_RS  = 3'b010;
    localparam logic [2:0] OP_RC  = 3'b011;
    localparam logic [2:0] OP_RWI = 3'b101;
    localparam logic [2:0] OP_RSI = 3'b110;
    localparam logic [2:0] OP_RCI = 3'b111;

    localparam logic [11:0] F12_MRET = 12'h302;
    localparam logic [11:0] F12_WFI  = 12'h105;

    typedef enum logic {ST_RUN, ST_SLEEP} csr_state_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam logic [1:0] MSTATUS_MPP = 2'b11;
    localparam int MIE_MEIE = 11;
    localparam int MIE_MTIE = 7;
    localparam int MIP_MEIP = 11;
    localparam int MIP_MTIP = 7;
    localparam logic [31:0] MIE_MASK = (32'd1 << MIE_MEIE) | (32'd1 << MIE_MTIE);

    // op[1:0]: 01 write, 10 set, 11 clear; same for register and immediate forms
    function automatic logic [31:0] csr_update(input logic [1:0] kind,
                                               input logic [31:0] old,
                                               input logic [31:0] src);
        case (kind)
            2'b01:   return src;
            2'b10:   return old | src;
            2'b11:   return old & ~src;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Free-running 64-bit event counter with increment enable.
module csr_counter64 #(
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [63:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= RST_VAL;
        else if (inc)
            value <= value + 64'd1;
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with interrupt trap entry, MRET and WFI sleep handling.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [63:0] MCYCLE_INIT   = 64'd0,
    parameter logic [63:0] MINSTRET_INIT = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  logic [2:0]  CSRcontrol,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  rs1_idx,
    input  logic [31:0] pc_ex,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic        retire,
    input  logic        ext_irq,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        wfi_stall
);

    csr_state_e  state, state_nxt;
    logic        mst_mie, mst_mpie;
    logic [31:0] mie_q, mepc_q, wfi_pc;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus, mip, src, wdata;
    logic        irq_pend, irq_take, commit, is_sys;
    logic        mret_commit, wfi_commit, write_en;

    csr_counter64 #(.RST_VAL(MCYCLE_INIT)) u_mcycle (
        .clk(clk), .rst_n(rst_n), .inc(1'b1), .value(mcycle)
    );

    csr_counter64 #(.RST_VAL(MINSTRET_INIT)) u_minstret (
        .clk(clk), .rst_n(rst_n), .inc(retire), .value(minstret)
    );

    always_comb begin
        mstatus = '0;
        mstatus[12:11] = MSTATUS_MPP;
        mstatus[MSTATUS_MIE] = mst_mie;
        mstatus[MSTATUS_MPIE] = mst_mpie;
        mip = '0;
        mip[MIP_MEIP] = ext_irq;
        mip[MIP_MTIP] = timer_irq;
    end

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS:                 csr_rdata = mstatus;
            CSR_MIE:                     csr_rdata = mie_q;
            CSR_MTVEC:                   csr_rdata = MTVEC_VAL;
            CSR_MEPC:                    csr_rdata = mepc_q;
            CSR_MIP:                     csr_rdata = mip;
            CSR_MCYCLE,   CSR_CYCLE:     csr_rdata = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    csr_rdata = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   csr_rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
            default:                     csr_rdata = '0;
        endcase
    end

    // A sleeping core takes an enabled interrupt even though EX is frozen.
    assign irq_pend = |(mie_q & mip);
    assign irq_take = mst_mie & irq_pend &
                      (((state == ST_RUN) & ex_valid & ~stall) | (state == ST_SLEEP));

    assign commit      = csr_en & ex_valid & ~stall & ~irq_take;
    assign is_sys      = (CSRcontrol == OP_SYS);
    assign mret_commit = commit & is_sys & (csr_addr == F12_MRET);
    assign wfi_commit  = commit & is_sys & (csr_addr == F12_WFI);

    // Set/clear with a zero rs1 index is a pure read.
    assign src      = CSRcontrol[2] ? {27'd0, rs1_idx} : rs1_data;
    assign wdata    = csr_update(CSRcontrol[1:0], csr_rdata, src);
    assign write_en = commit & (CSRcontrol[1:0] != 2'b00) &
                      ~(CSRcontrol[1] & (rs1_idx == 5'd0));

    assign redirect    = irq_take | mret_commit;
    assign redirect_pc = irq_take ? MTVEC_VAL : mepc_q;
    assign wfi_stall   = (state == ST_SLEEP) & ~irq_pend;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (wfi_commit) state_nxt = ST_SLEEP;
            ST_SLEEP: if (irq_pend)   state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie  <= 1'b0;
            mst_mpie <= 1'b0;
            mie_q    <= '0;
            mepc_q   <= '0;
            wfi_pc   <= '0;
        end else begin
            if (irq_take) begin
                mepc_q   <= (state == ST_SLEEP) ? wfi_pc : pc_ex;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_commit) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (write_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mst_mie  <= wdata[MSTATUS_MIE];
                        mst_mpie <= wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:  mie_q  <= wdata & MIE_MASK;
                    CSR_MEPC: mepc_q <= {wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (wfi_commit)
                wfi_pc <= pc_ex + 32'd4;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: CSR op table plus trap, MRET, WFI, counter and reset sequences.
module tb_csr_unit;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [2:0]  CSRcontrol = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [4:0]  rs1_idx = 5'd0;
    logic [31:0] pc_ex = 32'd0;
    logic        ex_valid = 1'b0;
    logic        stall = 1'b0;
    logic        retire = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        redirect, wfi_stall;

    // second instance preloaded near the counter boundaries
    logic [11:0] w_addr = 12'd0;
    logic        w_retire = 1'b0;
    logic        w_z1 = 1'b0;
    logic [2:0]  w_z3 = 3'd0;
    logic [4:0]  w_z5 = 5'd0;
    logic [31:0] w_z32 = 32'd0;
    logic [31:0] w_rdata, w_redirect_pc;
    logic        w_redirect, w_wfi_stall;

    int n_chk = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    csr_unit dut (
        .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .CSRcontrol(CSRcontrol),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .rs1_idx(rs1_idx), .pc_ex(pc_ex),
        .ex_valid(ex_valid), .stall(stall), .retire(retire), .ext_irq(ext_irq),
        .timer_irq(timer_irq), .csr_rdata(csr_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .wfi_stall(wfi_stall)
    );

    csr_unit #(
        .MCYCLE_INIT(64'h0000_0000_FFFF_FFFF),
        .MINSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFF)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .csr_en(w_z1), .CSRcontrol(w_z3),
        .csr_addr(w_addr), .rs1_data(w_z32), .rs1_idx(w_z5), .pc_ex(w_z32),
        .ex_valid(w_z1), .stall(w_z1), .retire(w_retire), .ext_irq(w_z1),
        .timer_irq(w_z1), .csr_rdata(w_rdata), .redirect(w_redirect),
        .redirect_pc(w_redirect_pc), .wfi_stall(w_wfi_stall)
    );

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] data;
        logic [4:0]  idx;
        logic [31:0] exp_old;
        logic [11:0] chk_addr;
        logic [31:0] exp_new;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    function automatic vec_t mk(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] data, input logic [4:0] idx,
                                input logic [31:0] exp_old, input logic [11:0] chk_addr,
                                input logic [31:0] exp_new);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.idx = idx;
        v.exp_old = exp_old; v.chk_addr = chk_addr; v.exp_new = exp_new;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        csr_en = 1'b0; ex_valid = 1'b0; stall = 1'b0; retire = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] data, input logic [4:0] idx, input logic [31:0] pc);
        csr_en = 1'b1; CSRcontrol = op; csr_addr = addr; rs1_data = data;
        rs1_idx = idx; pc_ex = pc; ex_valid = 1'b1; stall = 1'b0;
    endtask

    task automatic chk_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_en = 1'b0; csr_addr = a;
        #1 chk(name, csr_rdata, exp);
    endtask

    task automatic chk_wrap(input string name, input logic [11:0] a, input logic [31:0] exp);
        w_addr = a;
        #1 chk(name, w_rdata, exp);
    endtask

    initial begin
        logic [31:0] c0, c1;

        vt[0]  = mk(OP_RS,  12'h300, 32'hFFFF_FFFF, 5'd0,  32'h1800, 12'h300, 32'h1800);
        vt[1]  = mk(OP_RW,  12'h304, 32'h0000_0880, 5'd5,  32'h0,    12'h304, 32'h0880);
        vt[2]  = mk(OP_RSI, 12'h300, 32'hFFFF_FFFF, 5'd8,  32'h1800, 12'h300, 32'h1808);
        vt[3]  = mk(OP_RCI, 12'h300, 32'h0,         5'd8,  32'h1808, 12'h300, 32'h1800);
        vt[4]  = mk(OP_RW,  12'h341, 32'h0000_1237, 5'd1,  32'h0,    12'h341, 32'h1234);
        vt[5]  = mk(OP_RS,  12'h341, 32'h0000_0F00, 5'd1,  32'h1234, 12'h341, 32'h1F34);
        vt[6]  = mk(OP_RC,  12'h341, 32'h0000_0030, 5'd1,  32'h1F34, 12'h341, 32'h1F04);
        vt[7]  = mk(OP_RW,  12'h305, 32'hFFFF_FFFF, 5'd1,  32'h1_0000, 12'h305, 32'h1_0000);
        vt[8]  = mk(OP_RW,  12'h123, 32'h0000_0005, 5'd1,  32'h0,    12'h123, 32'h0);
        vt[9]  = mk(OP_RW,  12'h344, 32'hFFFF_FFFF, 5'd1,  32'h0,    12'h344, 32'h0);
        vt[10] = mk(OP_RW,  12'h304, 32'hFFFF_FFFF, 5'd1,  32'h0880, 12'h304, 32'h0880);
        vt[11] = mk(OP_RCI, 12'h304, 32'hFFFF_FFFF, 5'd0,  32'h0880, 12'h304, 32'h0880);
        vt[12] = mk(OP_RWI, 12'h300, 32'h0,         5'd8,  32'h1800, 12'h300, 32'h1808);
        vt[13] = mk(OP_RWI, 12'h300, 32'hFFFF_FFFF, 5'd0,  32'h1808, 12'h300, 32'h1800);
        vt[14] = mk(OP_RSI, 12'h300, 32'h0,         5'h1F, 32'h1800, 12'h300, 32'h1808);
        vt[15] = mk(OP_RC,  12'h300, 32'hFFFF_FFFF, 5'd3,  32'h1808, 12'h300, 32'h1800);
        vt[16] = mk(OP_RW,  12'hC02, 32'h0000_0055, 5'd1,  32'h0,    12'hB02, 32'h0);

        // reset state, both instances
        repeat (2) @(negedge clk);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_wfi_stall", {31'd0, wfi_stall}, 32'd0);
        chk_csr("rst_mstatus", 12'h300, 32'h1800);
        chk_csr("rst_mie", 12'h304, 32'h0);
        chk_csr("rst_mepc", 12'h341, 32'h0);
        chk_csr("rst_mcycle", 12'hB00, 32'h0);
        @(negedge clk);
        chk_csr("rst_minstret", 12'hB02, 32'h0);
        chk_wrap("wrap_rst_mcycle", 12'hB00, 32'hFFFF_FFFF);
        chk_wrap("wrap_rst_minstreth", 12'hB82, 32'hFFFF_FFFF);

        // counter boundaries: 32-bit carry into mcycleh, 64-bit wrap of minstret
        @(negedge clk);
        rst_n = 1'b1; w_retire = 1'b1;
        chk_wrap("wrap_pre_edge", 12'hB00, 32'hFFFF_FFFF);
        @(negedge clk);
        w_retire = 1'b0;
        chk_wrap("wrap_mcycle_lo", 12'hB00, 32'h0);
        chk_wrap("wrap_mcycle_hi", 12'hB80, 32'h1);
        chk_wrap("wrap_minstret_lo", 12'hB02, 32'h0);
        chk_wrap("wrap_minstret_hi", 12'hB82, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            issue(vt[i].op, vt[i].addr, vt[i].data, vt[i].idx, 32'h100);
            #1 chk($sformatf("vec%0d_old", i), csr_rdata, vt[i].exp_old);
            chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, 32'd0);
            @(negedge clk);
            idle();
            chk_csr($sformatf("vec%0d_new", i), vt[i].chk_addr, vt[i].exp_new);
        end

        // stalled or invalid instruction must not write
        @(negedge clk);
        issue(OP_RW, 12'h341, 32'hDEAD_BEEF, 5'd1, 32'h100); stall = 1'b1;
        @(negedge clk);
        idle(); chk_csr("stall_no_write", 12'h341, 32'h1F04);
        issue(OP_RW, 12'h341, 32'hDEAD_BEEF, 5'd1, 32'h100); ex_valid = 1'b0;
        @(negedge clk);
        idle(); chk_csr("invalid_no_write", 12'h341, 32'h1F04);

        // counters: 7 retires, then 100 stalled cycles
        retire = 1'b1;
        repeat (7) @(negedge clk);
        retire = 1'b0;
        chk_csr("instret_7", 12'hC02, 32'd7);
        csr_addr = 12'hB00; #1 c0 = csr_rdata;
        stall = 1'b1;
        repeat (100) @(negedge clk);
        csr_addr = 12'hB00; #1 c1 = csr_rdata;
        stall = 1'b0;
        chk("mcycle_delta", c1 - c0, 32'd100);
        chk_csr("minstret_held", 12'hB02, 32'd7);
        chk_csr("minstreth_zero", 12'hB82, 32'd0);

        // interrupt trap with a concurrent CSRRW squashed
        @(negedge clk);
        issue(OP_RSI, 12'h300, 32'h0, 5'd8, 32'h100);
        @(negedge clk);
        idle(); ext_irq = 1'b1;
        #1 chk("irq_no_valid", {31'd0, redirect}, 32'd0);
        @(negedge clk);
        ex_valid = 1'b1; stall = 1'b1;
        #1 chk("irq_stalled", {31'd0, redirect}, 32'd0);
        @(negedge clk);
        issue(OP_RW, 12'h341, 32'hDEAD_BEEC, 5'd1, 32'h200);
        #1 chk("trap_redirect", {31'd0, redirect}, 32'd1);
        chk("trap_pc", redirect_pc, 32'h0001_0000);
        @(negedge clk);
        idle(); ext_irq = 1'b0;
        chk_csr("trap_mepc", 12'h341, 32'h200);
        chk_csr("trap_mstatus", 12'h300, 32'h1880);
        chk("idle_redirect", {31'd0, redirect}, 32'd0);
        chk("idle_redirect_pc", redirect_pc, 32'h200);

        // MRET
        @(negedge clk);
        issue(OP_SYS, 12'h302, 32'h0, 5'd0, 32'h250);
        #1 chk("mret_redirect", {31'd0, redirect}, 32'd1);
        chk("mret_pc", redirect_pc, 32'h200);
        @(negedge clk);
        idle(); chk_csr("mret_mstatus", 12'h300, 32'h1888);

        // WFI with MIE=0: wake without redirect
        @(negedge clk);
        issue(OP_RCI, 12'h300, 32'h0, 5'd8, 32'h100);
        @(negedge clk);
        issue(OP_RW, 12'h304, 32'h80, 5'd1, 32'h100);
        @(negedge clk);
        issue(OP_SYS, 12'h105, 32'h0, 5'd0, 32'h300);
        #1 chk("wfi0_not_yet", {31'd0, wfi_stall}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            #1 chk($sformatf("wfi0_sleep%0d", i), {31'd0, wfi_stall}, 32'd1);
            chk($sformatf("wfi0_noredir%0d", i), {31'd0, redirect}, 32'd0);
        end
        timer_irq = 1'b1;
        #1 chk("wfi0_wake_stall", {31'd0, wfi_stall}, 32'd0);
        chk("wfi0_wake_redirect", {31'd0, redirect}, 32'd0);
        @(negedge clk);
        timer_irq = 1'b0;
        #1 chk("wfi0_back_run", {31'd0, wfi_stall}, 32'd0);
        chk_csr("wfi0_mepc", 12'h341, 32'h200);

        // WFI with MIE=1: trap out of sleep, mepc = wfi pc + 4
        @(negedge clk);
        issue(OP_RSI, 12'h300, 32'h0, 5'd8, 32'h100);
        @(negedge clk);
        issue(OP_SYS, 12'h105, 32'h0, 5'd0, 32'h300);
        @(negedge clk);
        idle();
        #1 chk("wfi1_sleep", {31'd0, wfi_stall}, 32'd1);
        @(negedge clk);
        timer_irq = 1'b1;
        #1 chk("wfi1_redirect", {31'd0, redirect}, 32'd1);
        chk("wfi1_pc", redirect_pc, 32'h0001_0000);
        chk("wfi1_stall", {31'd0, wfi_stall}, 32'd0);
        @(negedge clk);
        timer_irq = 1'b0;
        chk_csr("wfi1_mepc", 12'h341, 32'h304);
        chk_csr("wfi1_mstatus", 12'h300, 32'h1880);
        chk("wfi1_run", {31'd0, wfi_stall}, 32'd0);

        // mie write takes effect on the following cycle
        @(negedge clk);
        issue(OP_RSI, 12'h300, 32'h0, 5'd8, 32'h100);
        @(negedge clk);
        ext_irq = 1'b1;
        issue(OP_RW, 12'h304, 32'h800, 5'd1, 32'h400);
        #1 chk("mie_wr_same_cycle", {31'd0, redirect}, 32'd0);
        @(negedge clk);
        idle(); ex_valid = 1'b1; pc_ex = 32'h400;
        #1 chk("mie_wr_next_cycle", {31'd0, redirect}, 32'd1);
        @(negedge clk);
        idle(); ext_irq = 1'b0;
        chk_csr("mie_wr_mepc", 12'h341, 32'h400);

        // reset while sleeping
        @(negedge clk);
        issue(OP_SYS, 12'h105, 32'h0, 5'd0, 32'h500);
        @(negedge clk);
        idle();
        #1 chk("rstslp_sleep", {31'd0, wfi_stall}, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rstslp_stall", {31'd0, wfi_stall}, 32'd0);
        chk("rstslp_redirect", {31'd0, redirect}, 32'd0);
        chk_csr("rstslp_mstatus", 12'h300, 32'h1800);
        chk_csr("rstslp_mie", 12'h304, 32'h0);
        chk_csr("rstslp_mepc", 12'h341, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("rstslp_after", {31'd0, wfi_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 MTVEC_VAL, 32'h0001_0000, fixed trap vector; mtvec reads this value.
REQ-002 One clock, clk; all state updates on its rising edge. Reset rst_n is asynchronous, active-low.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 csr_en  input  1  EX instruction is SYSTEM (ALUsel 3'b111).
REQ-006 CSRcontrol  input  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI, 000 MRET/WFI.
REQ-007 csr_addr  input  12  inst[31:20]; for op 000, 12'h302 = MRET and 12'h105 = WFI.
REQ-008 rs1_data  input  32  forwarded rs1 value.
REQ-009 rs1_idx  input  5  inst[19:15]; zimm for immediate ops.
REQ-010 pc_ex  input  32  PC of EX instruction.
REQ-011 ex_valid  input  1  EX holds a valid, unflushed instruction.
REQ-012 stall  input  1  pipeline frozen this cycle.
REQ-013 retire  input  1  one instruction retired this cycle.
REQ-014 ext_irq  input  1  external interrupt level (MEIP).
REQ-015 timer_irq  input  1  timer interrupt level (MTIP).
REQ-016 csr_rdata  output  32  pre-update CSR value for rd.
REQ-017 redirect  output  1  flush and fetch from redirect_pc.
REQ-018 redirect_pc  output  32  redirect target.
REQ-019 wfi_stall  output  1  hold IF/ID/EX while sleeping.

Function
REQ-020 CSR map:
  - mstatus 300: MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; all other bits read 0.
  - mie 304: MEIE[11], MTIE[7].
  - mtvec 305: read-only, returns MTVEC_VAL.
  - mepc 341: bits[1:0] read 0.
  - mip 344: read-only, {ext_irq@11, timer_irq@7}.
  - mcycle/h B00/B80 and minstret/h B02/B82, aliased by cycle/h C00/C80 and instret/h C02/C82; all read-only.
  - Unimplemented addresses read 0 and ignore writes.
REQ-021 csr_rdata is combinational: the addressed CSR value before this cycle's edge.
REQ-022 Write value:
  - src = rs1_data for ops 001-011; src = zero-extended rs1_idx for ops 101-111.
  - RW: new = src. RS: new = old|src. RC: new = old&~src.
REQ-023 Write commits at the edge only when csr_en & ex_valid & ~stall & ~irq_take; RS/RC/RSI/RCI with rs1_idx==0 perform no write.
REQ-024 Counters:
  - mcycle: 64-bit, increments every cycle, including stall and SLEEP.
  - minstret: 64-bit, increments when retire=1.
  - Both wrap from 2^64-1 to 0, with carry from bit 31 into the high word.
REQ-025 Interrupt terms:
  - irq_pend = |(mie & mip).
  - irq_take = MIE & irq_pend & ((RUN & ex_valid & ~stall) | SLEEP).
REQ-026 FSM {RUN, SLEEP}:
  - RUN->SLEEP when WFI commits (csr_en, op 000, addr 105, ex_valid, ~stall, ~irq_take); wfi_pc <= pc_ex+4 on that edge.
  - SLEEP->RUN when irq_pend, regardless of MIE.
REQ-027 wfi_stall = (state==SLEEP) & ~irq_pend.
REQ-028 Trap (irq_take):
  - Same cycle: redirect=1, redirect_pc=MTVEC_VAL.
  - At the edge: mepc <= pc_ex (RUN) or wfi_pc (SLEEP); MPIE <= MIE; MIE <= 0.
  - The EX instruction is squashed (no CSR, MRET or WFI effect).
REQ-029 MRET commit:
  - Same cycle: redirect=1, redirect_pc=mepc.
  - At the edge: MIE <= MPIE; MPIE <= 1.
REQ-030 Wake from SLEEP with MIE=0: no redirect; execution resumes with the held instruction.
REQ-031 Priority: irq_take > MRET > WFI > CSR write. Otherwise redirect=0 and redirect_pc=mepc.
REQ-032 A CSR write to MIE or mie affects irq_take from the following cycle.

Reset
REQ-033 While rst_n=0: state=RUN, MIE=MPIE=0, mie=0, mepc=0, wfi_pc=0, counters=0; hence redirect=0, wfi_stall=0, mstatus reads 32'h0000_1800.
REQ-034 Reset asserted during SLEEP or during a redirect cycle aborts it; no pending trap survives reset.

Structure
REQ-035 csr_pkg holds: CSR address constants, CSRcontrol codes, MRET/WFI funct12 values, state enum, and mstatus/mie/mip bit positions.
REQ-036 Sub-module csr_counter64 (inc enable, 64-bit value, async active-low reset) is instantiated for mcycle and minstret.

Verification
REQ-037 Reset, then CSRRS addr 300, rs1_idx=0 -> csr_rdata=32'h0000_1800; mstatus unchanged.
REQ-038 CSRRW 304, rs1_data=32'h880, then CSRRSI 300 zimm=8 -> mie=32'h880; next CSRRCI 300 zimm=8 returns 32'h1808, then mstatus=32'h1800.
REQ-039 MIE=1, MEIE=1, ext_irq=1, ex_valid, pc_ex=32'h200 -> redirect=1, redirect_pc=32'h10000; next cycle mepc=32'h200, mstatus=32'h1880; a concurrent CSRRW is not written.
REQ-040 MRET with mepc=32'h200, MPIE=1 -> redirect_pc=32'h200; mstatus=32'h1888.
REQ-041 WFI at pc 32'h300, MTIE=1, MIE=0 -> wfi_stall=1 until timer_irq=1, then wfi_stall=0 with no redirect. Repeat with MIE=1 -> redirect to 32'h10000, mepc=32'h304.
REQ-042 Counters:
  - 100 stalled cycles -> mcycle +100, minstret unchanged.
  - mcycle=32'hFFFF_FFFF -> next cycle mcycleh +1, mcycle=0.
